// File: rtl/motor_niveles_tamagotchi_if.sv
// Bus between the pet stat engine and its surroundings: tick/action pulses in,
// registered levels and life state out.
interface motor_niveles_tamagotchi_if;
   logic       tick;
   logic       B_Test;
   logic       B_Alimentar;
   logic       B_Jugar;
   logic       B_Dormir;
   logic       B_Curar;
   logic [1:0] Nivel_Animo;
   logic [1:0] Nivel_Energia;
   logic [1:0] Nivel_Descanso;
   logic [1:0] Nivel_Salud;
   logic       Durmiendo;
   logic       Muerto;

   modport master (
      output tick, B_Test, B_Alimentar, B_Jugar, B_Dormir, B_Curar,
      input  Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Salud, Durmiendo, Muerto
   );

   modport slave (
      input  tick, B_Test, B_Alimentar, B_Jugar, B_Dormir, B_Curar,
      output Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Salud, Durmiendo, Muerto
   );
endinterface

// File: rtl/motor_niveles_tamagotchi.sv
// Pet stat engine: tick-driven decay, action-driven rises, sleep/awake/dead FSM.
// Optional SALUD_ACOPLADA_EN halves the Salud decay period while any other stat is 0.
//
// state     | meaning
// DESPIERTO | awake: all four stats decay, feed/play/heal/sleep accepted
// DURMIENDO | asleep: Descanso refills on its own counter, only B_Dormir accepted
// MUERTO    | dead: everything frozen until B_Reset
module motor_niveles_tamagotchi #(
   parameter int Tiempo_De_Cambio = 10,
   parameter int Tiempo_Salud     = 20,
   parameter int Tiempo_Sueno     = 5
) (
   input logic                       clk,
   input logic                       B_Reset,
   motor_niveles_tamagotchi_if.slave bus
);
   localparam int W_C = $clog2(Tiempo_De_Cambio + 1);
   localparam int W_S = $clog2(Tiempo_Salud + 1);
   localparam int W_Z = $clog2(Tiempo_Sueno + 1);
   localparam int SALUD_MEDIO = ((Tiempo_Salud / 2) < 1) ? 1 : (Tiempo_Salud / 2);

   localparam logic [W_C-1:0] FIN_C       = W_C'(Tiempo_De_Cambio - 1);
   localparam logic [W_S-1:0] FIN_S       = W_S'(Tiempo_Salud - 1);
   localparam logic [W_S-1:0] FIN_S_MEDIO = W_S'(SALUD_MEDIO - 1);
   localparam logic [W_Z-1:0] FIN_Z       = W_Z'(Tiempo_Sueno - 1);

   // encoding chosen so Durmiendo/Muerto are plain register bits
   typedef enum logic [1:0] {
      DESPIERTO = 2'b00,
      DURMIENDO = 2'b01,
      MUERTO    = 2'b10
   } estado_t;

   estado_t        estado_q, estado_d;
   logic [1:0]     animo_q, animo_d;
   logic [1:0]     energia_q, energia_d;
   logic [1:0]     descanso_q, descanso_d;
   logic [1:0]     salud_q, salud_d;
   logic [W_C-1:0] cnt_a_q, cnt_a_d;
   logic [W_C-1:0] cnt_e_q, cnt_e_d;
   logic [W_C-1:0] cnt_d_q, cnt_d_d;
   logic [W_S-1:0] cnt_s_q, cnt_s_d;
   logic [W_Z-1:0] cnt_z_q, cnt_z_d;

   logic           despierto, dormido;
   logic           al, ju, cu;
   logic           ev_a, ev_e, ev_d, ev_s, sube;
   logic [W_S-1:0] fin_s;

   // level + inc - dec, clamped to 0..3
   function automatic logic [1:0] sat_lvl(input logic [1:0] lvl, input logic [1:0] inc,
                                          input logic [1:0] dec);
      logic [2:0] suma;
      suma = {1'b0, lvl} + {1'b0, inc};
      if (suma < {1'b0, dec}) return 2'd0;
      suma = suma - {1'b0, dec};
      return (suma > 3'd3) ? 2'd3 : suma[1:0];
   endfunction

   always_ff @(posedge clk or negedge B_Reset) begin
      if (!B_Reset) begin
         estado_q   <= DESPIERTO;
         animo_q    <= 2'd3;
         energia_q  <= 2'd3;
         descanso_q <= 2'd3;
         salud_q    <= 2'd3;
         cnt_a_q    <= '0;
         cnt_e_q    <= '0;
         cnt_d_q    <= '0;
         cnt_s_q    <= '0;
         cnt_z_q    <= '0;
      end else begin
         estado_q   <= estado_d;
         animo_q    <= animo_d;
         energia_q  <= energia_d;
         descanso_q <= descanso_d;
         salud_q    <= salud_d;
         cnt_a_q    <= cnt_a_d;
         cnt_e_q    <= cnt_e_d;
         cnt_d_q    <= cnt_d_d;
         cnt_s_q    <= cnt_s_d;
         cnt_z_q    <= cnt_z_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      animo_d    = animo_q;
      energia_d  = energia_q;
      descanso_d = descanso_q;
      salud_d    = salud_q;
      cnt_a_d    = cnt_a_q;
      cnt_e_d    = cnt_e_q;
      cnt_d_d    = cnt_d_q;
      cnt_s_d    = cnt_s_q;
      cnt_z_d    = cnt_z_q;
      ev_a       = 1'b0;
      ev_e       = 1'b0;
      ev_d       = 1'b0;
      ev_s       = 1'b0;
      sube       = 1'b0;
      despierto  = (estado_q == DESPIERTO);
      dormido    = (estado_q == DURMIENDO);
      al         = despierto & bus.B_Alimentar;
      ju         = despierto & bus.B_Jugar;
      cu         = despierto & bus.B_Curar;
      fin_s      = FIN_S;
`ifdef SALUD_ACOPLADA_EN
      if (animo_q == 2'd0 || energia_q == 2'd0 || descanso_q == 2'd0) fin_s = FIN_S_MEDIO;
`endif

      if (estado_q != MUERTO) begin
         if (bus.B_Test) begin
            cnt_a_d = '0;
            ev_a    = bus.tick;
         end else if (bus.tick) begin
            if (cnt_a_q >= FIN_C) begin
               cnt_a_d = '0;
               ev_a    = 1'b1;
            end else begin
               cnt_a_d = cnt_a_q + W_C'(1);
            end
         end
         if (ju) cnt_a_d = '0;

         if (bus.B_Test) begin
            cnt_e_d = '0;
            ev_e    = bus.tick;
         end else if (bus.tick) begin
            if (cnt_e_q >= FIN_C) begin
               cnt_e_d = '0;
               ev_e    = 1'b1;
            end else begin
               cnt_e_d = cnt_e_q + W_C'(1);
            end
         end
         if (al | ju) cnt_e_d = '0;

         // Descanso decay prescaler is paused while asleep
         if (despierto) begin
            if (bus.B_Test) begin
               cnt_d_d = '0;
               ev_d    = bus.tick;
            end else if (bus.tick) begin
               if (cnt_d_q >= FIN_C) begin
                  cnt_d_d = '0;
                  ev_d    = 1'b1;
               end else begin
                  cnt_d_d = cnt_d_q + W_C'(1);
               end
            end
         end

         // >= so a counter already past a freshly halved period fires on the next tick
         if (bus.B_Test) begin
            cnt_s_d = '0;
            ev_s    = bus.tick;
         end else if (bus.tick) begin
            if (cnt_s_q >= fin_s) begin
               cnt_s_d = '0;
               ev_s    = 1'b1;
            end else begin
               cnt_s_d = cnt_s_q + W_S'(1);
            end
         end
         if (cu) cnt_s_d = '0;

         if (dormido) begin
            if (bus.tick) begin
               if (cnt_z_q >= FIN_Z) begin
                  cnt_z_d = '0;
                  sube    = 1'b1;
               end else begin
                  cnt_z_d = cnt_z_q + W_Z'(1);
               end
            end
         end else begin
            cnt_z_d = '0;
         end

         animo_d    = sat_lvl(animo_q, {1'b0, ju}, {1'b0, ev_a});
         energia_d  = sat_lvl(energia_q, {1'b0, al}, {1'b0, ju} + {1'b0, ev_e});
         descanso_d = sat_lvl(descanso_q, {1'b0, sube}, {1'b0, ev_d});
         salud_d    = sat_lvl(salud_q, {1'b0, cu}, {1'b0, ev_s});

         if (salud_q == 2'd0) begin
            estado_d = MUERTO;
         end else if (despierto && bus.B_Dormir) begin
            estado_d = DURMIENDO;
         end else if (dormido && (bus.B_Dormir || descanso_d == 2'd3)) begin
            estado_d = DESPIERTO;
         end
      end
   end

   assign bus.Nivel_Animo    = animo_q;
   assign bus.Nivel_Energia  = energia_q;
   assign bus.Nivel_Descanso = descanso_q;
   assign bus.Nivel_Salud    = salud_q;
   assign bus.Durmiendo      = estado_q[0];
   assign bus.Muerto         = estado_q[1];
endmodule

// File: tb/tb_motor_niveles_tamagotchi.sv
// Bench for the pet stat engine: stat-array reference model checked every cycle,
// plus hand-computed level checks at the key points of each scenario.
module tb_motor_niveles_tamagotchi;
   localparam int TC = 10;
   localparam int TS = 20;
   localparam int TZ = 5;

   logic clk;
   logic B_Reset;
   int   n_cmp;
   int   n_bad;
   bit   run_chk;

   // reference model: index 0 Animo, 1 Energia, 2 Descanso, 3 Salud; est 0 awake, 1 asleep, 2 dead
   int   m_lvl[4];
   int   m_cnt[4];
   int   m_per[4];
   int   m_sue;
   int   m_est;

   motor_niveles_tamagotchi_if bus ();

   motor_niveles_tamagotchi #(
      .Tiempo_De_Cambio(TC),
      .Tiempo_Salud    (TS),
      .Tiempo_Sueno    (TZ)
   ) dut (
      .clk    (clk),
      .B_Reset(B_Reset),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_lvl[i] = 3;
         m_cnt[i] = 0;
      end
      m_sue = 0;
      m_est = 0;
   endtask

   task automatic model_step();
      int  inc[4];
      int  dec[4];
      bit  clr[4];
      int  p;
      int  v;
      bit  aw;
      bit  sl;
      bit  muere;
      aw = (m_est == 0);
      sl = (m_est == 1);
      for (int i = 0; i < 4; i++) begin
         inc[i] = 0;
         dec[i] = 0;
         clr[i] = 1'b0;
      end
      if (aw) begin
         if (bus.B_Alimentar) begin inc[1]++; clr[1] = 1'b1; end
         if (bus.B_Jugar) begin inc[0]++; dec[1]++; clr[0] = 1'b1; clr[1] = 1'b1; end
         if (bus.B_Curar) begin inc[3]++; clr[3] = 1'b1; end
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 2 && !aw) continue;
         p = m_per[i];
`ifdef SALUD_ACOPLADA_EN
         if (i == 3 && (m_lvl[0] == 0 || m_lvl[1] == 0 || m_lvl[2] == 0))
            p = ((m_per[3] / 2) < 1) ? 1 : m_per[3] / 2;
`endif
         if (bus.B_Test) begin
            m_cnt[i] = 0;
            if (bus.tick) dec[i]++;
         end else if (bus.tick) begin
            m_cnt[i]++;
            if (m_cnt[i] >= p) begin
               m_cnt[i] = 0;
               dec[i]++;
            end
         end
         if (clr[i]) m_cnt[i] = 0;
      end
      if (sl) begin
         if (bus.tick) begin
            m_sue++;
            if (m_sue >= TZ) begin
               m_sue = 0;
               inc[2]++;
            end
         end
      end else begin
         m_sue = 0;
      end
      muere = (m_lvl[3] == 0);
      for (int i = 0; i < 4; i++) begin
         v = m_lvl[i] + inc[i] - dec[i];
         m_lvl[i] = (v < 0) ? 0 : ((v > 3) ? 3 : v);
      end
      if (muere) m_est = 2;
      else if (aw && bus.B_Dormir) m_est = 1;
      else if (sl && (bus.B_Dormir || m_lvl[2] == 3)) m_est = 0;
   endtask

   initial begin
      m_per[0] = TC;
      m_per[1] = TC;
      m_per[2] = TC;
      m_per[3] = TS;
      model_reset();
      forever begin
         @(posedge clk or negedge B_Reset);
         if (!B_Reset) model_reset();
         else if (m_est != 2) model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (run_chk) begin
            chk("animo", int'(bus.Nivel_Animo), m_lvl[0]);
            chk("energia", int'(bus.Nivel_Energia), m_lvl[1]);
            chk("descanso", int'(bus.Nivel_Descanso), m_lvl[2]);
            chk("salud", int'(bus.Nivel_Salud), m_lvl[3]);
            chk("durmiendo", int'(bus.Durmiendo), int'(m_est == 1));
            chk("muerto", int'(bus.Muerto), int'(m_est == 2));
         end
      end
   end

   // inputs for one clock, applied just after a falling edge
   task automatic drive(input logic t, input logic a, input logic j, input logic d,
                        input logic c);
      bus.tick        = t;
      bus.B_Alimentar = a;
      bus.B_Jugar     = j;
      bus.B_Dormir    = d;
      bus.B_Curar     = c;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic do_reset();
      bus.B_Test = 1'b0;
      #2 B_Reset = 1'b0;
      @(negedge clk);
      chk("lit_rst_salud", int'(bus.Nivel_Salud), 3);
      chk("lit_rst_muerto", int'(bus.Muerto), 0);
      @(negedge clk);
      #2 B_Reset = 1'b1;
      @(negedge clk);
   endtask

   logic [4:0] pat[12];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      run_chk = 1'b0;
      B_Reset = 1'b0;
      bus.tick = 1'b0;
      bus.B_Test = 1'b0;
      bus.B_Alimentar = 1'b0;
      bus.B_Jugar = 1'b0;
      bus.B_Dormir = 1'b0;
      bus.B_Curar = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 B_Reset = 1'b1;
      @(negedge clk);
      run_chk = 1'b1;
      chk("lit_reset_animo", int'(bus.Nivel_Animo), 3);
      chk("lit_reset_descanso", int'(bus.Nivel_Descanso), 3);
      chk("lit_reset_durmiendo", int'(bus.Durmiendo), 0);

      // decay after the 10th tick
      ticks(9);
      chk("lit_9ticks_animo", int'(bus.Nivel_Animo), 3);
      ticks(1);
      chk("lit_10ticks_animo", int'(bus.Nivel_Animo), 2);
      chk("lit_10ticks_energia", int'(bus.Nivel_Energia), 2);
      chk("lit_10ticks_descanso", int'(bus.Nivel_Descanso), 2);
      chk("lit_10ticks_salud", int'(bus.Nivel_Salud), 3);
      ticks(10);
      chk("lit_20ticks_energia", int'(bus.Nivel_Energia), 1);
      chk("lit_20ticks_salud", int'(bus.Nivel_Salud), 2);

      // feeding saturates at 3
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lit_feed1", int'(bus.Nivel_Energia), 2);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lit_feed2", int'(bus.Nivel_Energia), 3);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lit_feed3", int'(bus.Nivel_Energia), 3);

      // sleep from Descanso 1, heal ignored, wake at Descanso 3
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("lit_sleep_durmiendo", int'(bus.Durmiendo), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lit_sleep_curar", int'(bus.Nivel_Salud), 2);
      ticks(5);
      chk("lit_sleep5_descanso", int'(bus.Nivel_Descanso), 2);
      ticks(5);
      chk("lit_sleep10_descanso", int'(bus.Nivel_Descanso), 3);
      chk("lit_sleep10_durmiendo", int'(bus.Durmiendo), 0);
      ticks(3);

      // test mode drains everything, death, frozen, reset revives
      do_reset();
      bus.B_Test = 1'b1;
      ticks(2);
      chk("lit_test2_animo", int'(bus.Nivel_Animo), 1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lit_test3_salud", int'(bus.Nivel_Salud), 0);
      chk("lit_test3_energia", int'(bus.Nivel_Energia), 0);
      chk("lit_test3_muerto", int'(bus.Muerto), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lit_dead_muerto", int'(bus.Muerto), 1);
      bus.B_Test = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lit_dead_salud", int'(bus.Nivel_Salud), 0);
      chk("lit_dead_animo", int'(bus.Nivel_Animo), 0);
      chk("lit_dead_durmiendo", int'(bus.Durmiendo), 0);
      do_reset();
      chk("lit_revive_salud", int'(bus.Nivel_Salud), 3);
      chk("lit_revive_muerto", int'(bus.Muerto), 0);

      // play coinciding with an Energia decay event
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      ticks(3);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(7);
      chk("lit_pre_animo", int'(bus.Nivel_Animo), 2);
      chk("lit_pre_energia", int'(bus.Nivel_Energia), 2);
      ticks(2);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("lit_coinc_animo", int'(bus.Nivel_Animo), 3);
      chk("lit_coinc_energia", int'(bus.Nivel_Energia), 0);
      chk("lit_coinc_salud", int'(bus.Nivel_Salud), 3);

      // Salud period with Energia held at 0
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("lit_e0_energia", int'(bus.Nivel_Energia), 0);
      ticks(20);
      chk("lit_e0_animo", int'(bus.Nivel_Animo), 1);
`ifdef SALUD_ACOPLADA_EN
      chk("lit_e0_salud", int'(bus.Nivel_Salud), 1);
`else
      chk("lit_e0_salud", int'(bus.Nivel_Salud), 2);
`endif

      // mixed action vectors {tick, alimentar, jugar, dormir, curar}
      do_reset();
      pat[0]  = 5'b10000; pat[1]  = 5'b01100; pat[2]  = 5'b10001; pat[3]  = 5'b00000;
      pat[4]  = 5'b11100; pat[5]  = 5'b00010; pat[6]  = 5'b10100; pat[7]  = 5'b10001;
      pat[8]  = 5'b00010; pat[9]  = 5'b10110; pat[10] = 5'b00001; pat[11] = 5'b10000;
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 12; k++) begin
            drive(pat[k][4], pat[k][3], pat[k][2], pat[k][1], pat[k][0]);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      run_chk = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
